// File: rtl/zvc_pkg.sv
// zvc_pkg: shared default widths, mode bit indices, typedefs and count-width helper for the zero-value compressor
package zvc_pkg;
  localparam int ZVC_WORD_WIDTH    = 8;
  localparam int ZVC_LINE_SIZE     = 32;
  localparam int ZVC_DIST_WIDTH    = 7;
  localparam int ZVC_MAX_LIFM_RSIZ = 3;
  localparam int MT_W              = ZVC_DIST_WIDTH * ZVC_MAX_LIFM_RSIZ;
  localparam int MODE_MSRC = 0;
  localparam int MODE_BYP  = 1;
  typedef logic [ZVC_WORD_WIDTH-1:0] lifm_word_t;
  typedef logic [MT_W-1:0] mt_entry_t;
  function automatic int cnt_width(input int n);
    return $clog2(n + 1);
  endfunction
endpackage

// File: rtl/zvc_prefix_sum.sv
// zvc_prefix_sum: Ladner-Fischer (minimum-depth form) exclusive prefix count of a keep mask, plus total
module zvc_prefix_sum #(
  parameter int N         = 32,
  parameter int CNT_WIDTH = $clog2(N + 1)
) (
  input  logic [N-1:0]           mask,
  output logic [N*CNT_WIDTH-1:0] sums,
  output logic [CNT_WIDTH-1:0]   total
);
  localparam int LV = $clog2(N);
  logic [CNT_WIDTH-1:0] s [LV+1][N];
  always_comb begin
    for (int i = 0; i < N; i++) s[0][i] = CNT_WIDTH'(mask[i]);
    // each level folds in the running sum of the block immediately below
    for (int l = 0; l < LV; l++)
      for (int i = 0; i < N; i++)
        if (((i >> l) & 1) == 1) s[l+1][i] = s[l][i] + s[l][((i >> l) << l) - 1];
        else s[l+1][i] = s[l][i];
    sums = '0;
    for (int i = 0; i < N; i++) sums[i*CNT_WIDTH +: CNT_WIDTH] = s[LV][i] - CNT_WIDTH'(mask[i]);
    total = s[LV][N-1];
  end
endmodule

// File: rtl/zvc_stream_compressor.sv
// zvc_stream_compressor: 3-stage valid/ready zero-value compressor packing kept LIFM words and MT entries to low slots
module zvc_stream_compressor
  import zvc_pkg::*;
#(
  parameter int WORD_WIDTH    = ZVC_WORD_WIDTH,
  parameter int LINE_SIZE     = ZVC_LINE_SIZE,
  parameter int DIST_WIDTH    = ZVC_DIST_WIDTH,
  parameter int MAX_LIFM_RSIZ = ZVC_MAX_LIFM_RSIZ,
  parameter int CNT_WIDTH     = cnt_width(LINE_SIZE)
) (
  input  logic                                       clk,
  input  logic                                       reset,
  input  logic                                       in_valid,
  output logic                                       in_ready,
  input  logic [1:0]                                 in_mode,
  input  logic [LINE_SIZE*WORD_WIDTH-1:0]            lifm_line,
  input  logic [LINE_SIZE*DIST_WIDTH*MAX_LIFM_RSIZ-1:0] mt_line,
  output logic                                       out_valid,
  input  logic                                       out_ready,
  output logic [LINE_SIZE*WORD_WIDTH-1:0]            lifm_comp,
  output logic [LINE_SIZE*DIST_WIDTH*MAX_LIFM_RSIZ-1:0] mt_comp,
  output logic [LINE_SIZE-1:0]                       bitmask,
  output logic [CNT_WIDTH-1:0]                       count
);
  localparam int MW = DIST_WIDTH * MAX_LIFM_RSIZ;
  localparam int LW = LINE_SIZE * WORD_WIDTH;
  localparam int TW = LINE_SIZE * MW;
  localparam int DW = LINE_SIZE * CNT_WIDTH;

  logic adv1, adv2, adv3, ld1, ld2, ld3;
  logic v1_q, v1_d, v2_q, v2_d, v3_q, v3_d;
  logic [LINE_SIZE-1:0] in_mask, mask1_q, mask1_d, mask2_q, mask2_d, mask3_q, mask3_d;
  logic [LW-1:0] lifm1_q, lifm1_d, lifm2_q, lifm2_d, lifm3_q, lifm3_d, sc_lifm;
  logic [TW-1:0] mt1_q, mt1_d, mt2_q, mt2_d, mt3_q, mt3_d, sc_mt;
  logic [DW-1:0] dest, dest2_q, dest2_d;
  logic [CNT_WIDTH-1:0] total, tot2_q, tot2_d, cnt3_q, cnt3_d;

  assign adv3     = !v3_q || out_ready;
  assign adv2     = !v2_q || adv3;
  assign adv1     = !v1_q || adv2;
  assign in_ready = adv1;
  assign ld1      = adv1 && in_valid;
  assign ld2      = adv2 && v1_q;
  assign ld3      = adv3 && v2_q;

  // bypass keeps every word, so the identity scatter falls out of the normal path
  always_comb begin
    in_mask = '0;
    for (int i = 0; i < LINE_SIZE; i++)
      in_mask[i] = in_mode[MODE_BYP] || (in_mode[MODE_MSRC] ? |mt_line[i*MW +: MW]
                                                            : |lifm_line[i*WORD_WIDTH +: WORD_WIDTH]);
  end

  zvc_prefix_sum #(.N(LINE_SIZE), .CNT_WIDTH(CNT_WIDTH)) u_prefix (
    .mask  (mask1_q),
    .sums  (dest),
    .total (total)
  );

  // one-hot per slot: at most one kept source word carries a given destination
  always_comb begin
    sc_lifm = '0;
    sc_mt   = '0;
    for (int j = 0; j < LINE_SIZE; j++)
      for (int i = 0; i < LINE_SIZE; i++)
        if (mask2_q[i] && dest2_q[i*CNT_WIDTH +: CNT_WIDTH] == CNT_WIDTH'(j)) begin
          sc_lifm[j*WORD_WIDTH +: WORD_WIDTH] = sc_lifm[j*WORD_WIDTH +: WORD_WIDTH] | lifm2_q[i*WORD_WIDTH +: WORD_WIDTH];
          sc_mt[j*MW +: MW] = sc_mt[j*MW +: MW] | mt2_q[i*MW +: MW];
        end
  end

  always_comb begin
    v1_d    = adv1 ? in_valid : v1_q;
    lifm1_d = ld1 ? lifm_line : lifm1_q;
    mt1_d   = ld1 ? mt_line : mt1_q;
    mask1_d = ld1 ? in_mask : mask1_q;
    v2_d    = adv2 ? v1_q : v2_q;
    lifm2_d = ld2 ? lifm1_q : lifm2_q;
    mt2_d   = ld2 ? mt1_q : mt2_q;
    mask2_d = ld2 ? mask1_q : mask2_q;
    dest2_d = ld2 ? dest : dest2_q;
    tot2_d  = ld2 ? total : tot2_q;
    v3_d    = adv3 ? v2_q : v3_q;
    lifm3_d = ld3 ? sc_lifm : lifm3_q;
    mt3_d   = ld3 ? sc_mt : mt3_q;
    mask3_d = ld3 ? mask2_q : mask3_q;
    cnt3_d  = ld3 ? tot2_q : cnt3_q;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      v1_q    <= 1'b0;
      v2_q    <= 1'b0;
      v3_q    <= 1'b0;
      lifm1_q <= '0;
      mt1_q   <= '0;
      mask1_q <= '0;
      lifm2_q <= '0;
      mt2_q   <= '0;
      mask2_q <= '0;
      dest2_q <= '0;
      tot2_q  <= '0;
      lifm3_q <= '0;
      mt3_q   <= '0;
      mask3_q <= '0;
      cnt3_q  <= '0;
    end else begin
      v1_q    <= v1_d;
      v2_q    <= v2_d;
      v3_q    <= v3_d;
      lifm1_q <= lifm1_d;
      mt1_q   <= mt1_d;
      mask1_q <= mask1_d;
      lifm2_q <= lifm2_d;
      mt2_q   <= mt2_d;
      mask2_q <= mask2_d;
      dest2_q <= dest2_d;
      tot2_q  <= tot2_d;
      lifm3_q <= lifm3_d;
      mt3_q   <= mt3_d;
      mask3_q <= mask3_d;
      cnt3_q  <= cnt3_d;
    end
  end

  assign out_valid = v3_q;
  assign lifm_comp = lifm3_q;
  assign mt_comp   = mt3_q;
  assign bitmask   = mask3_q;
  assign count     = cnt3_q;
endmodule
